apu_reg_writer: RTL

- Converts a byte stream from the UART receiver into APU register writes for the pulse-1 and noise channels.
- Frame format: one address byte followed by one data byte.
- Holds the register images that drive the channel generators. Emits the per-channel reload strobes (reg_event) that restart the length counters.
- Sits between the serial front end and the sound channels. It is the writer end of the register interface those channels read.

---
 rtl/apu_reg_writer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/apu_reg_writer.sv
// -----------------------------------------------------------------------------
// apu_reg_writer
//
// Turns the byte stream coming out of the UART receiver into APU register
// writes for the pulse-1 and noise channels. Each frame is an address byte
// (3'b100 in bits [7:5], register offset in bits [4:0]) followed by a data
// byte. The block holds the register images the channel generators read and
// raises a one-cycle reload strobe when a length register is written.
//
// Parameters:
//   TIMEOUT       cycles allowed between address and data byte (min 1)
//
// Ports:
//   clk           system clock (APU clock domain)
//   rst_n         asynchronous active-low reset
//   rx_data       received byte, meaningful only while rx_valid is high
//   rx_valid      one-cycle strobe per received byte, may assert every cycle
//   reg_4000..    pulse-1 register images ($4000-$4003)
//   reg_400C..    noise register images ($400C, $400E, $400F)
//   pulse1_event  one-cycle strobe, first cycle the new reg_4003 is visible
//   noise_event   one-cycle strobe, first cycle the new reg_400F is visible
//   frame_error   one-cycle strobe on a bad address byte or a data timeout
//   busy          high while an address has been taken and data is awaited
// -----------------------------------------------------------------------------
module apu_reg_writer #(
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] reg_4000,
    output logic [7:0] reg_4001,
    output logic [7:0] reg_4002,
    output logic [7:0] reg_4003,
    output logic [7:0] reg_400C,
    output logic [7:0] reg_400E,
    output logic [7:0] reg_400F,
    output logic       pulse1_event,
    output logic       noise_event,
    output logic       frame_error,
    output logic       busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        WAIT_DATA
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [4:0]       offset;
    logic [CNT_W-1:0] cnt;

    // Decoded conditions shared by the state logic and the datapath.
    logic addr_ok;
    logic addr_take;
    logic data_take;
    logic timeout_hit;
    logic error_next;

    assign addr_ok     = (rx_data[7:5] == 3'b100);
    assign addr_take   = (state == IDLE) && rx_valid && addr_ok;
    assign data_take   = (state == WAIT_DATA) && rx_valid;
    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout_hit = (state == WAIT_DATA) && !rx_valid && (cnt == CNT_LAST);
    assign error_next  = ((state == IDLE) && rx_valid && !addr_ok) || timeout_hit;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches on paths that do not change state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (addr_take) begin
                    state_next = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (rx_valid || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs decoded from state
    // -------------------------------------------------------------------------
    always_comb begin
        busy = (state == WAIT_DATA);
    end

    // -------------------------------------------------------------------------
    // Offset latch and timeout counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset <= 5'h00;
            cnt    <= '0;
        end else if (addr_take) begin
            offset <= rx_data[4:0];
            cnt    <= '0;
        end else if ((state == WAIT_DATA) && !rx_valid && (cnt != CNT_LAST)) begin
            // Saturates at the last count; the state leaves WAIT_DATA there.
            cnt <= cnt + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Register images and strobes
    // -------------------------------------------------------------------------
    // Strobes are registered on the same edge as the image write, so each one
    // coincides with the first cycle the updated image is visible.
    // NOTE: the images are a handful of discrete flops, not a memory array,
    // so they take the asynchronous reset like the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_4000     <= 8'h00;
            reg_4001     <= 8'h00;
            reg_4002     <= 8'h00;
            reg_4003     <= 8'h00;
            reg_400C     <= 8'h00;
            reg_400E     <= 8'h00;
            reg_400F     <= 8'h00;
            pulse1_event <= 1'b0;
            noise_event  <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            pulse1_event <= data_take && (offset == 5'h03);
            noise_event  <= data_take && (offset == 5'h0F);
            frame_error  <= error_next;
            if (data_take) begin
                // Unmapped offsets swallow the data byte without side effects.
                case (offset)
                    5'h00:   reg_4000 <= rx_data;
                    5'h01:   reg_4001 <= rx_data;
                    5'h02:   reg_4002 <= rx_data;
                    5'h03:   reg_4003 <= rx_data;
                    5'h0C:   reg_400C <= rx_data;
                    5'h0E:   reg_400E <= rx_data;
                    5'h0F:   reg_400F <= rx_data;
                    default: ;
                endcase
            end
        end
    end

endmodule
